// File: rtl/calc_pkg.sv
// Shared definitions for the calculator keypad/display path: key codes,
// entry-FSM states and the BCD digit type.
package calc_pkg;

  localparam logic [3:0] KEY_CLEAR = 4'hA;
  localparam logic [3:0] KEY_BKSP  = 4'hB;
  localparam logic [3:0] KEY_ENTER = 4'hC;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_e;

  typedef logic [3:0] bcd_t;

  // True for the decimal digit codes 0..9.
  function automatic logic is_digit_key(input logic [3:0] code);
    return (code <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_key_entry_mul10_add.sv
// One decimal accumulate step: y = acc*10 + d, computed as shifts and adds
// in W+4 bits, then truncated back to W bits.
module mul10_add #(
  parameter int W = 14
) (
  input  logic [W-1:0] acc,
  input  logic [3:0]   d,
  output logic [W-1:0] y
);

  logic [W+3:0] acc_wide;
  logic [W+3:0] sum_wide;

  // acc*10 = acc*8 + acc*2, plus the incoming digit
  always_comb begin
    acc_wide = {4'b0000, acc};
    sum_wide = (acc_wide << 3) + (acc_wide << 1) + {{W{1'b0}}, d};
    y        = sum_wide[W-1:0];
  end

endmodule

// File: rtl/bcd_key_entry.sv
// Keypad entry block: collects decimal key presses into a packed-BCD entry
// for the display and, on ENTER, converts the entry MSD-first to binary.
//
// Strobe semantics: key_valid is a one-cycle strobe with no back-pressure;
// every cycle it is high is one key press, sampled on that posedge. A key
// that cannot be honoured (entry full, backspace on empty, or any key while
// busy) is dropped and answered by a one-cycle key_err pulse. bin_valid is a
// one-cycle pulse that marks the cycle in which bin_out first holds a new
// result; the consumer has no ready and must take it on that cycle.
module bcd_key_entry
  import calc_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int W    = 14
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                key_valid,
  input  logic [3:0]          key_code,
  output logic [4*NDIG-1:0]   digits,
  output logic [2:0]          ndig,
  output logic                busy,
  output logic                bin_valid,
  output logic [W-1:0]        bin_out,
  output logic                key_err
);

  localparam int             IW       = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [2:0]     NDIG_MAX = 3'(NDIG);
  localparam logic [IW-1:0]  IDX_TOP  = IW'(NDIG - 1);

  state_e            state;
  state_e            state_nxt;
  logic [IW-1:0]     idx;
  logic [W-1:0]      acc;
  logic [W-1:0]      acc_nxt;
  logic              last_iter;
  bcd_t              cur_digit;
  logic [4*NDIG+3:0] shl_full;
  logic [4*NDIG-1:0] digits_shl;
  logic [4*NDIG-1:0] digits_shr;
  logic [4*NDIG-1:0] digits_sel;

  // Entry shift helpers and the digit currently addressed by the converter
  always_comb begin
    shl_full   = {digits, key_code};
    digits_shl = shl_full[4*NDIG-1:0];
    digits_shr = digits >> 4;
    digits_sel = digits >> {idx, 2'b00};
    cur_digit  = digits_sel[3:0];
    last_iter  = (idx == '0);
  end

  mul10_add #(.W(W)) u_mul10_add (
    .acc (acc),
    .d   (cur_digit),
    .y   (acc_nxt)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next state: ENTER starts a conversion, the last iteration ends it
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (key_valid && (key_code == KEY_ENTER)) state_nxt = CONV;
      CONV: if (last_iter) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == CONV);

  // Entry register, conversion datapath and output pulses
  always_ff @(posedge CLK) begin
    if (RST) begin
      digits    <= '0;
      ndig      <= '0;
      idx       <= '0;
      acc       <= '0;
      bin_out   <= '0;
      bin_valid <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      bin_valid <= 1'b0;
      key_err   <= 1'b0;
      if (state == CONV) begin
        // Keys are never queued during a conversion, including the final edge.
        if (key_valid) key_err <= 1'b1;
        acc <= acc_nxt;
        idx <= idx - 1'b1;
        if (last_iter) begin
          bin_out   <= acc_nxt;
          bin_valid <= 1'b1;
        end
      end else if (key_valid) begin
        if (is_digit_key(key_code)) begin
          if (ndig == NDIG_MAX) begin
            key_err <= 1'b1;
          end else if (!((ndig == 3'd0) && (key_code == 4'd0))) begin
            // A leading zero is silently dropped so the entry stays canonical.
            digits <= digits_shl;
            ndig   <= ndig + 3'd1;
          end
        end else if (key_code == KEY_CLEAR) begin
          digits <= '0;
          ndig   <= '0;
        end else if (key_code == KEY_BKSP) begin
          if (ndig == 3'd0) begin
            key_err <= 1'b1;
          end else begin
            digits <= digits_shr;
            ndig   <= ndig - 3'd1;
          end
        end else if (key_code == KEY_ENTER) begin
          acc <= '0;
          idx <= IDX_TOP;
        end
        // 0xD..0xF are reserved and ignored without an error.
      end
    end
  end

endmodule

// File: tb/tb_bcd_key_entry.sv
// Bench for bcd_key_entry: directed key sequences followed by random key
// traffic, every cycle compared against a digit-list reference model.
module tb_bcd_key_entry;

  localparam int NDIG = 4;
  localparam int W    = 14;
  localparam logic [3:0] K_CLR = 4'hA;
  localparam logic [3:0] K_BS  = 4'hB;
  localparam logic [3:0] K_ENT = 4'hC;

  logic                CLK;
  logic                RST;
  logic                key_valid;
  logic [3:0]          key_code;
  logic [4*NDIG-1:0]   digits;
  logic [2:0]          ndig;
  logic                busy;
  logic                bin_valid;
  logic [W-1:0]        bin_out;
  logic                key_err;

  int checks;
  int failures;

  // reference model state
  int m_dq[$];       // entered digits, most significant first
  int m_busy_left;   // conversion edges still to come
  int m_conv_val;    // value captured at ENTER
  int m_bin;
  int m_bv;
  int m_kerr;
  int bv_count;

  // clock and reset block
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  bcd_key_entry #(.NDIG(NDIG), .W(W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .key_valid (key_valid),
    .key_code  (key_code),
    .digits    (digits),
    .ndig      (ndig),
    .busy      (busy),
    .bin_valid (bin_valid),
    .bin_out   (bin_out),
    .key_err   (key_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int entry_value();
    int v = 0;
    foreach (m_dq[i]) v = v * 10 + m_dq[i];
    return v;
  endfunction

  function automatic logic [4*NDIG-1:0] entry_bcd();
    logic [4*NDIG-1:0] b = '0;
    foreach (m_dq[i]) b = (b << 4) | (4*NDIG)'(m_dq[i]);
    return b;
  endfunction

  // scoreboard: apply one clock edge worth of key semantics to the model
  task automatic model_edge(input logic rst, input logic v, input logic [3:0] code);
    m_bv   = 0;
    m_kerr = 0;
    if (rst) begin
      m_dq.delete();
      m_busy_left = 0;
      m_bin = 0;
    end else if (m_busy_left > 0) begin
      if (v) m_kerr = 1;
      m_busy_left--;
      if (m_busy_left == 0) begin
        m_bin = m_conv_val;
        m_bv  = 1;
      end
    end else if (v) begin
      if (code <= 4'd9) begin
        if (m_dq.size() == NDIG) m_kerr = 1;
        else if (!(m_dq.size() == 0 && code == 4'd0)) m_dq.push_back(int'(code));
      end else if (code == K_CLR) begin
        m_dq.delete();
      end else if (code == K_BS) begin
        if (m_dq.size() == 0) m_kerr = 1;
        else void'(m_dq.pop_back());
      end else if (code == K_ENT) begin
        m_conv_val  = entry_value();
        m_busy_left = NDIG;
      end
    end
  endtask

  // driver: one cycle of stimulus, then compare every output
  task automatic cycle(input logic rst, input logic v, input logic [3:0] code);
    RST       = rst;
    key_valid = v;
    key_code  = code;
    @(posedge CLK);
    model_edge(rst, v, code);
    #1;
    check("digits",    32'(digits),    32'(entry_bcd()));
    check("ndig",      32'(ndig),      32'(m_dq.size()));
    check("busy",      32'(busy),      32'(m_busy_left > 0));
    check("bin_valid", 32'(bin_valid), 32'(m_bv));
    check("bin_out",   32'(bin_out),   32'(m_bin));
    check("key_err",   32'(key_err),   32'(m_kerr));
    if (bin_valid) bv_count++;
    @(negedge CLK);
  endtask

  task automatic press(input logic [3:0] code);
    cycle(1'b0, 1'b1, code);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bv_count = 0;
    m_busy_left = 0;
    m_conv_val = 0;
    m_bin = 0;
    RST = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    @(negedge CLK);
    cycle(1'b1, 1'b0, 4'h0);
    cycle(1'b1, 1'b0, 4'h0);
    check("rst_digits", 32'(digits), 32'h0);

    // 1,2,3,4 ENTER: result pulse exactly NDIG cycles later
    press(4'd1); press(4'd2); press(4'd3); press(4'd4);
    check("d1234", 32'(digits), 32'h1234);
    bv_count = 0;
    press(K_ENT);
    idle(3);
    check("no_early_bv", 32'(bv_count), 32'd0);
    idle(1);
    check("bv_at_4", 32'(bin_valid), 32'd1);
    check("bin1234", 32'(bin_out), 32'd1234);

    // full entry, fifth digit rejected
    press(K_CLR);
    press(4'd9); press(4'd9); press(4'd9); press(4'd9); press(4'd5);
    check("err_on_5", 32'(key_err), 32'd1);
    press(K_ENT); idle(NDIG);
    check("bin9999", 32'(bin_out), 32'h270F);

    // leading zeros, backspace
    press(K_CLR);
    press(4'd0); press(4'd0); press(4'd7); press(K_BS); press(4'd5);
    check("d0005", 32'(digits), 32'h0005);
    press(K_ENT); idle(NDIG);
    check("bin5", 32'(bin_out), 32'd5);
    press(K_CLR); press(K_BS);
    check("bs_empty_err", 32'(key_err), 32'd1);

    // key while busy, then CLEAR keeps bin_out
    press(4'd4); press(4'd2); press(K_ENT); press(4'd3);
    check("busy_err", 32'(key_err), 32'd1);
    idle(NDIG);
    check("bin42", 32'(bin_out), 32'd42);
    press(K_CLR);
    check("clr_keeps_bin", 32'(bin_out), 32'd42);

    // empty ENTER, unused codes
    bv_count = 0;
    press(K_ENT); idle(NDIG + 2);
    check("empty_bv_once", 32'(bv_count), 32'd1);
    check("bin0", 32'(bin_out), 32'd0);
    press(4'hD); press(4'hE); press(4'hF);

    // reset during conversion abandons it
    press(4'd8); press(4'd8);
    bv_count = 0;
    press(K_ENT); idle(1);
    cycle(1'b1, 1'b0, 4'h0);
    idle(NDIG + 2);
    check("rst_no_bv", 32'(bv_count), 32'd0);

    // random traffic, including back-to-back strobes and occasional reset
    for (int i = 0; i < 3000; i++) begin
      logic       r;
      logic       v;
      logic [3:0] c;
      int         sel;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 99) < 60);
      sel = $urandom_range(0, 99);
      if (sel < 65)      c = 4'($urandom_range(0, 9));
      else if (sel < 72) c = K_CLR;
      else if (sel < 84) c = K_BS;
      else if (sel < 95) c = K_ENT;
      else               c = 4'($urandom_range(13, 15));
      cycle(r, v, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
